// File: rtl/ex_stage.sv
// Execute stage: input pipeline register, 32-bit ALU, data RAM drive and a
// 32-step restoring divider that holds the pipeline while it iterates.
module ex_stage (
    input  logic         clk,
    input  logic         rst,
    input  logic [6:0]   stall,
    input  logic [140:0] id_to_ex_bus,
    output logic [75:0]  ex_to_mem_bus,
    output logic [38:0]  ex_to_id_bus,
    output logic         data_sram_en,
    output logic [3:0]   data_sram_wen,
    output logic [31:0]  data_sram_addr,
    output logic [31:0]  data_sram_wdata,
    output logic         stallreq_for_ex
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;
    localparam logic [3:0] OP_LUI  = 4'd10;
    localparam logic [3:0] OP_DIV  = 4'd11;
    localparam logic [3:0] OP_DIVU = 4'd12;

    typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_e;

    logic [140:0] ex_bus_q, ex_bus_d;

    always_comb begin
        ex_bus_d = ex_bus_q;
        if (stall[2] && !stall[3]) begin
            ex_bus_d = '0;
        end else if (!stall[2]) begin
            ex_bus_d = id_to_ex_bus;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) ex_bus_q <= '0;
        else     ex_bus_q <= ex_bus_d;
    end

    logic [31:0] pc, src_a, src_b, store_data;
    logic [3:0]  alu_op;
    logic [4:0]  rf_waddr;
    logic        rf_we, sel_rf_res, mem_en, mem_we;

    assign pc         = ex_bus_q[140:109];
    assign alu_op     = ex_bus_q[108:105];
    assign rf_waddr   = ex_bus_q[104:100];
    assign rf_we      = ex_bus_q[99];
    assign sel_rf_res = ex_bus_q[98];
    assign mem_en     = ex_bus_q[97];
    assign mem_we     = ex_bus_q[96];
    assign src_a      = ex_bus_q[95:64];
    assign src_b      = ex_bus_q[63:32];
    assign store_data = ex_bus_q[31:0];

    logic unused_stall;
    assign unused_stall = ^{stall[6:4], stall[1:0]};

    // Divider state; the dividend is shifted out of quo_q as quotient bits shift in
    div_state_e  div_state_q, div_state_d;
    logic [4:0]  div_cnt_q, div_cnt_d;
    logic [31:0] div_rem_q, div_rem_d;
    logic [31:0] div_quo_q, div_quo_d;
    logic [31:0] div_dsr_q, div_dsr_d;
    logic        div_neg_q, div_neg_d;

    logic        is_div, is_signed, a_neg, b_neg;
    logic [32:0] rem_shift;
    logic [31:0] rem_diff, div_result;
    logic        rem_ge;

    assign is_div     = (alu_op == OP_DIV) || (alu_op == OP_DIVU);
    assign is_signed  = (alu_op == OP_DIV);
    assign a_neg      = is_signed & src_a[31];
    assign b_neg      = is_signed & src_b[31];
    assign rem_shift  = {div_rem_q, div_quo_q[31]};
    assign rem_ge     = rem_shift >= {1'b0, div_dsr_q};
    assign rem_diff   = rem_shift[31:0] - div_dsr_q;
    assign div_result = div_neg_q ? (32'd0 - div_quo_q) : div_quo_q;

    always_comb begin
        div_state_d = div_state_q;
        div_cnt_d   = div_cnt_q;
        div_rem_d   = div_rem_q;
        div_quo_d   = div_quo_q;
        div_dsr_d   = div_dsr_q;
        div_neg_d   = div_neg_q;
        case (div_state_q)
            DIV_IDLE: begin
                if (is_div) begin
                    div_quo_d   = a_neg ? (32'd0 - src_a) : src_a;
                    div_dsr_d   = b_neg ? (32'd0 - src_b) : src_b;
                    // A zero divisor must yield all-ones regardless of signs
                    div_neg_d   = (a_neg ^ b_neg) && (src_b != 32'd0);
                    div_rem_d   = '0;
                    div_cnt_d   = '0;
                    div_state_d = DIV_BUSY;
                end
            end
            DIV_BUSY: begin
                div_rem_d = rem_ge ? rem_diff : rem_shift[31:0];
                div_quo_d = {div_quo_q[30:0], rem_ge};
                div_cnt_d = div_cnt_q + 5'd1;
                if (div_cnt_q == 5'd31) div_state_d = DIV_DONE;
            end
            DIV_DONE: begin
                if (!stall[3]) div_state_d = DIV_IDLE;
            end
            default: div_state_d = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_state_q <= DIV_IDLE;
            div_cnt_q   <= '0;
            div_rem_q   <= '0;
            div_quo_q   <= '0;
            div_dsr_q   <= '0;
            div_neg_q   <= 1'b0;
        end else begin
            div_state_q <= div_state_d;
            div_cnt_q   <= div_cnt_d;
            div_rem_q   <= div_rem_d;
            div_quo_q   <= div_quo_d;
            div_dsr_q   <= div_dsr_d;
            div_neg_q   <= div_neg_d;
        end
    end

    assign stallreq_for_ex = is_div && (div_state_q != DIV_DONE);

    logic [4:0]  sh;
    logic [31:0] alu_res, ex_result;

    assign sh = src_a[4:0];

    always_comb begin
        alu_res = '0;
        case (alu_op)
            OP_ADD:  alu_res = src_a + src_b;
            OP_SUB:  alu_res = src_a - src_b;
            OP_AND:  alu_res = src_a & src_b;
            OP_OR:   alu_res = src_a | src_b;
            OP_XOR:  alu_res = src_a ^ src_b;
            OP_SLL:  alu_res = src_b << sh;
            OP_SRL:  alu_res = src_b >> sh;
            OP_SRA:  alu_res = $signed(src_b) >>> sh;
            OP_SLT:  alu_res = {31'd0, $signed(src_a) < $signed(src_b)};
            OP_SLTU: alu_res = {31'd0, src_a < src_b};
            OP_LUI:  alu_res = src_b << 16;
            OP_DIV, OP_DIVU: alu_res = (div_state_q == DIV_DONE) ? div_result : 32'd0;
            default: alu_res = '0;
        endcase
    end

    // Memory ops always use the adder for the effective address
    assign ex_result = mem_en ? (src_a + src_b) : alu_res;

    assign data_sram_en    = mem_en;
    assign data_sram_wen   = (mem_en && mem_we) ? 4'b1111 : 4'b0000;
    assign data_sram_addr  = {ex_result[31:2], 2'b00};
    assign data_sram_wdata = store_data;

    assign ex_to_mem_bus = {pc, data_sram_en, data_sram_wen, sel_rf_res, rf_we, rf_waddr, ex_result};
    assign ex_to_id_bus  = {mem_en & ~mem_we, rf_we, rf_waddr, ex_result};

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 clk  in  1  clock; all state updates on posedge clk.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 stall  in  7  stall vector; bit 2 = ID, bit 3 = EX; Stop=1, NoStop=0.
REQ-004 id_to_ex_bus  in  141  layout:
- [140:109] pc
- [108:105] alu_op
- [104:100] rf_waddr
- [99] rf_we
- [98] sel_rf_res
- [97] mem_en
- [96] mem_we
- [95:64] src_a
- [63:32] src_b
- [31:0] store_data
REQ-005 ex_to_mem_bus  out  76  layout:
- [75:44] pc
- [43] data_ram_en
- [42:39] data_ram_wen
- [38] sel_rf_res
- [37] rf_we
- [36:32] rf_waddr
- [31:0] ex_result
REQ-006 ex_to_id_bus  out  39  {is_load, rf_we, rf_waddr, ex_result}, for ID forwarding and load-use detection.
REQ-007 data_sram_en  out  1  data RAM enable.
REQ-008 data_sram_wen  out  4  byte write enables.
REQ-009 data_sram_addr  out  32  data RAM address.
REQ-010 data_sram_wdata  out  32  store data.
REQ-011 stallreq_for_ex  out  1  EX requests a pipeline stall (divider busy).

Function
REQ-012 Input register update, in priority order:
- rst: clear to 0.
- stall[2]=Stop and stall[3]=NoStop: clear to 0 (bubble).
- stall[2]=NoStop: load id_to_ex_bus.
- Otherwise: hold.
REQ-013 alu_op encoding; all arithmetic is 32-bit, wrap-around, no overflow trap:
- 0 ADD a+b; 1 SUB a-b; 2 AND; 3 OR; 4 XOR
- 5 SLL b<<a[4:0]; 6 SRL; 7 SRA (arithmetic)
- 8 SLT (signed, result 0/1); 9 SLTU (unsigned, result 0/1)
- 10 LUI b<<16
- 11 DIV signed quotient; 12 DIVU unsigned quotient
- 13-15: result 0
REQ-014 When mem_en=1, ex_result is src_a+src_b regardless of alu_op.
REQ-015 Data RAM drive:
- data_sram_en = mem_en
- data_sram_addr = {ex_result[31:2], 2'b00}
- data_sram_wen = 4'b1111 if mem_en and mem_we, else 4'b0000
- data_sram_wdata = store_data
REQ-016 ex_to_mem_bus data_ram_en and data_ram_wen mirror data_sram_en and data_sram_wen.
REQ-017 ex_to_id_bus is_load = mem_en & ~mem_we.
REQ-018 Divider FSM states: IDLE, BUSY, DONE.
REQ-019 IDLE with alu_op 11/12: latch operand magnitudes and sign info, count=0, go to BUSY.
REQ-020 BUSY: one restoring shift-subtract step per cycle; count increments; after the step at count=31, go to DONE.
REQ-021 DONE: quotient is valid on ex_result; return to IDLE on a cycle with stall[3]=NoStop, otherwise hold DONE.
REQ-022 stallreq_for_ex = (alu_op is 11 or 12) and state != DONE, combinational.
- Op enters at cycle 0; stallreq is high for cycles 0-32; cycle 33 is DONE with stallreq low.
REQ-023 Signed DIV: quotient negated when operand signs differ; 0x80000000 / -1 = 0x80000000.
REQ-024 Divisor 0, DIV or DIVU: quotient 0xFFFFFFFF, same 33-cycle latency.
REQ-025 While a divide is not in DONE, ex_result for alu_op 11/12 is 0; rf_we is passed through unchanged (MEM is held by the stall).
REQ-026 Non-divide ops complete combinationally in the same cycle; stallreq_for_ex stays 0.
REQ-027 Bubble (all-zero register): rf_we=0, data_sram_en=0, data_sram_wen=0, ex_result=0.

Reset
REQ-028 rst clears the input register and divider state (to IDLE, count=0, quotient=0) in the same edge.
REQ-029 After reset: every output is 0, including stallreq_for_ex.
REQ-030 rst during BUSY aborts the divide; no result is produced.

Verification
REQ-031 Enter ADD (a=0x7FFFFFFF, b=1, rf_we=1, waddr=5) -> next cycle ex_result=0x80000000, ex_to_id_bus={0,1,5,0x80000000}.
REQ-032 Store: mem_en=1, mem_we=1, a=0x1003, b=4, store_data=0xDEADBEEF -> data_sram_addr=0x1004, wen=4'hF, wdata=0xDEADBEEF, ex_to_mem_bus[43]=1.
REQ-033 DIV a=-7, b=2, with stall[3] driven from stallreq_for_ex -> stallreq high exactly 33 cycles, then ex_result=0xFFFFFFFD; next NoStop edge returns FSM to IDLE.
REQ-034 DIVU a=5, b=0 -> after 33 cycles ex_result=0xFFFFFFFF.
REQ-035 stall=7'b0000111 with a valid ID op -> EX register loads 0; all outputs 0 next cycle.
REQ-036 rst asserted at BUSY count=10 -> next cycle state IDLE, stallreq_for_ex=0, all outputs 0.
